uart_rx_fifo: RTL and testbench

- Parametrised UART receiver: the next generation of the single-byte 9600-baud receiver driving the LED matrix display.
- Adds configurable clock/baud, data width, parity, stop bits, glitch rejection, error flags, and a receive FIFO with a valid/ready output handshake.
- Sits between the UART_RX pin and display or command logic on the iCE40 feather.
- Runs on the 12 MHz board clock.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 46 ++++
 rtl/uart_rx_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART receive path: parity modes,
// receiver FSM states and the bit-period calculation.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } rxState_t;

   // Rounded number of system clocks per serial bit.
   function automatic int clks_per_bit(input int clk, input int baud);
      return (clk + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with head-of-queue read data and no fall-through.
// A pop while full frees the slot that a same-cycle push then uses.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             doPush;
   logic             doPop;

   // The extra pointer bit distinguishes full from empty when the indices match.
   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign rdata  = mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with glitch rejection, sticky error flags and
// a receive FIFO presented through a valid/ready handshake.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 12_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   input  logic                 clr_err,
   output logic                 busy
);

   localparam int             CPB       = clks_per_bit(CLK_FREQ, BAUD);
   localparam int             CW        = $clog2(CPB);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(CPB - 1);
   localparam logic [CW-1:0]  CNT_HALF  = CW'(CPB / 2);
   localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);
   localparam logic           STOP_LAST = (STOP_BITS == 2);

   logic                 rxMeta;
   logic                 rxs;
   rxState_t             state;
   logic [CW-1:0]        bitCnt;
   logic [3:0]           bitIdx;
   logic                 stopIdx;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 perrFrame;
   logic                 ferrFrame;
   logic                 bitWrap;
   logic                 parXor;
   logic                 parBad;
   logic                 frameDone;
   logic                 frameFerr;
   logic                 frameGood;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic                 pop;
   logic                 overrunSet;

   always_ff @(posedge clk) begin
      if (rst) begin
         rxMeta <= 1'b1;
         rxs    <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxs    <= rxMeta;
      end
   end

   assign bitWrap = (bitCnt == CNT_LAST);
   assign parXor  = (^shiftReg) ^ rxs;
   assign parBad  = (PARITY == PAR_ODD) ? !parXor : parXor;

   // The current stop sample is folded in so the decision lands on the sampling cycle.
   assign frameDone  = (state == STOP) && bitWrap && (stopIdx == STOP_LAST);
   assign frameFerr  = ferrFrame || !rxs;
   assign frameGood  = frameDone && !frameFerr && !perrFrame;
   assign pop        = ready && !fifoEmpty;
   assign overrunSet = frameGood && fifoFull && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bitCnt    <= '0;
         bitIdx    <= '0;
         stopIdx   <= 1'b0;
         shiftReg  <= '0;
         perrFrame <= 1'b0;
         ferrFrame <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state  <= START;
                  bitCnt <= '0;
               end
            end
            START: begin
               if (bitCnt == CNT_HALF) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     state     <= DATA;
                     bitCnt    <= '0;
                     bitIdx    <= '0;
                     perrFrame <= 1'b0;
                     ferrFrame <= 1'b0;
                  end
               end else begin
                  bitCnt <= bitCnt + 1'b1;
               end
            end
            DATA: begin
               if (bitWrap) begin
                  bitCnt   <= '0;
                  shiftReg <= {rxs, shiftReg[DATA_BITS-1:1]};
                  if (bitIdx == BIT_LAST) begin
                     bitIdx  <= '0;
                     stopIdx <= 1'b0;
                     state   <= (PARITY != PAR_NONE) ? PAR : STOP;
                  end else begin
                     bitIdx <= bitIdx + 1'b1;
                  end
               end else begin
                  bitCnt <= bitCnt + 1'b1;
               end
            end
            PAR: begin
               if (bitWrap) begin
                  bitCnt    <= '0;
                  perrFrame <= parBad;
                  stopIdx   <= 1'b0;
                  state     <= STOP;
               end else begin
                  bitCnt <= bitCnt + 1'b1;
               end
            end
            STOP: begin
               if (bitWrap) begin
                  bitCnt <= '0;
                  if (!rxs) ferrFrame <= 1'b1;
                  if (stopIdx == STOP_LAST) begin
                     state <= IDLE;
                  end else begin
                     stopIdx <= 1'b1;
                  end
               end else begin
                  bitCnt <= bitCnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A set event in the same cycle as clr_err keeps the flag raised.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err  <= (frameDone && frameFerr) || (frame_err && !clr_err);
         parity_err <= (frameDone && perrFrame) || (parity_err && !clr_err);
         overrun    <= overrunSet || (overrun && !clr_err);
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) rxFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (frameGood),
      .pop   (pop),
      .wdata (shiftReg),
      .rdata (data),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   assign valid = !fifoEmpty;
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E2 instance at 16 clocks
// per bit, checked against a frame-level reference model.
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxN = 1'b1, readyN = 1'b0, clrN = 1'b0;
   logic       rxE = 1'b1, readyE = 1'b0, clrE = 1'b0;
   logic [7:0] dataN, dataE;
   logic       validN, ferrN, perrN, ovrN, busyN;
   logic       validE, ferrE, perrE, ovrE, busyE;

   int checkCount = 0;
   int passCount  = 0;

   logic [7:0] expN[$], expE[$], gotN[$], gotE[$];
   int         occN = 0, occE = 0;
   bit         mFerrN = 0, mPerrN = 0, mOvrN = 0;
   bit         mFerrE = 0, mPerrE = 0, mOvrE = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
   ) dutN (
      .clk(clk), .rst(rst), .rx(rxN), .data(dataN), .valid(validN),
      .ready(readyN), .frame_err(ferrN), .parity_err(perrN),
      .overrun(ovrN), .clr_err(clrN), .busy(busyN)
   );

   uart_rx_fifo #(
      .CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
      .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
   ) dutE (
      .clk(clk), .rst(rst), .rx(rxE), .data(dataE), .valid(validE),
      .ready(readyE), .frame_err(ferrE), .parity_err(perrE),
      .overrun(ovrE), .clr_err(clrE), .busy(busyE)
   );

   // Scoreboard of every word the consumer side actually takes.
   always @(posedge clk) begin
      if (!rst) begin
         if (validN && readyN) gotN.push_back(dataN);
         if (validE && readyE) gotE.push_back(dataE);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitTicks(input int n);
      repeat (n) tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic setRx(input bit toE, input logic v);
      if (toE) rxE = v;
      else     rxN = v;
   endtask

   task automatic driveBit(input bit toE, input logic v);
      setRx(toE, v);
      waitTicks(CPB);
   endtask

   // Frame-level model: a good frame joins the queue unless the queue is full.
   task automatic modelFrame(input bit toE, input logic [7:0] d, input logic p,
                             input logic s0, input logic s1);
      bit fe, pe;
      fe = !s0 || (toE && !s1);
      pe = toE && ((($countones(d) + int'(p)) % 2) != 0);
      if (toE) begin
         if (fe) mFerrE = 1;
         if (pe) mPerrE = 1;
         if (!fe && !pe) begin
            if (readyE || occE < DEPTH) begin
               expE.push_back(d);
               if (!readyE) occE++;
            end else mOvrE = 1;
         end
      end else begin
         if (fe) mFerrN = 1;
         if (!fe) begin
            if (readyN || occN < DEPTH) begin
               expN.push_back(d);
               if (!readyN) occN++;
            end else mOvrN = 1;
         end
      end
   endtask

   task automatic applyStimulus(input bit toE, input logic [7:0] d, input logic p,
                                input logic s0, input logic s1);
      driveBit(toE, 1'b0);
      for (int i = 0; i < 8; i++) driveBit(toE, d[i]);
      if (toE) driveBit(toE, p);
      driveBit(toE, s0);
      if (toE) driveBit(toE, s1);
      setRx(toE, 1'b1);
      modelFrame(toE, d, p, s0, s1);
   endtask

   task automatic checkFlags(input bit toE);
      if (toE) begin
         checkOutput("frame_errE", 32'(ferrE), 32'(mFerrE));
         checkOutput("parity_errE", 32'(perrE), 32'(mPerrE));
         checkOutput("overrunE", 32'(ovrE), 32'(mOvrE));
      end else begin
         checkOutput("frame_errN", 32'(ferrN), 32'(mFerrN));
         checkOutput("parity_errN", 32'(perrN), 32'(mPerrN));
         checkOutput("overrunN", 32'(ovrN), 32'(mOvrN));
      end
   endtask

   task automatic compareGot(input bit toE);
      if (toE) begin
         checkOutput("popCountE", 32'(gotE.size()), 32'(expE.size()));
         for (int i = 0; i < expE.size() && i < gotE.size(); i++)
            checkOutput("popDataE", 32'(gotE[i]), 32'(expE[i]));
         gotE.delete();
         expE.delete();
      end else begin
         checkOutput("popCountN", 32'(gotN.size()), 32'(expN.size()));
         for (int i = 0; i < expN.size() && i < gotN.size(); i++)
            checkOutput("popDataN", 32'(gotN[i]), 32'(expN[i]));
         gotN.delete();
         expN.delete();
      end
   endtask

   task automatic drainCheck(input bit toE);
      if (toE) readyE = 1'b1;
      else     readyN = 1'b1;
      waitTicks(8);
      readyE = 1'b0;
      readyN = 1'b0;
      tick();
      compareGot(toE);
      if (toE) begin
         checkOutput("drainedValidE", 32'(validE), 32'(1'b0));
         occE = 0;
      end else begin
         checkOutput("drainedValidN", 32'(validN), 32'(1'b0));
         occN = 0;
      end
   endtask

   task automatic clearErr(input bit toE);
      if (toE) clrE = 1'b1;
      else     clrN = 1'b1;
      tick();
      clrE = 1'b0;
      clrN = 1'b0;
      if (toE) begin
         mFerrE = 0; mPerrE = 0; mOvrE = 0;
      end else begin
         mFerrN = 0; mPerrN = 0; mOvrN = 0;
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       p, s0, s1, badP;
      logic [7:0] a5;

      $display("[TB] start");
      waitTicks(3);
      rst = 1'b0;
      tick();
      checkOutput("resetValidN", 32'(validN), 32'(1'b0));
      checkOutput("resetBusyN", 32'(busyN), 32'(1'b0));
      checkOutput("resetValidE", 32'(validE), 32'(1'b0));
      checkOutput("resetBusyE", 32'(busyE), 32'(1'b0));
      checkFlags(1'b0);
      checkFlags(1'b1);

      // Single 8N1 frame, head visible before any pop.
      applyStimulus(1'b0, 8'h42, 1'b0, 1'b1, 1'b1);
      waitTicks(2);
      checkOutput("busyAfterStopN", 32'(busyN), 32'(1'b0));
      checkOutput("validAfterFrameN", 32'(validN), 32'(1'b1));
      checkOutput("headDataN", 32'(dataN), 32'(8'h42));
      checkFlags(1'b0);
      drainCheck(1'b0);

      // Two frames with the consumer always ready.
      readyN = 1'b1;
      applyStimulus(1'b0, 8'h42, 1'b0, 1'b1, 1'b1);
      waitTicks(50);
      applyStimulus(1'b0, 8'h43, 1'b0, 1'b1, 1'b1);
      waitTicks(10);
      readyN = 1'b0;
      tick();
      compareGot(1'b0);

      // Short low pulse on an idle line is rejected at the mid-bit check.
      rxN = 1'b0;
      waitTicks(4);
      rxN = 1'b1;
      waitTicks(2);
      checkOutput("glitchBusyN", 32'(busyN), 32'(1'b1));
      waitTicks(20);
      checkOutput("glitchIdleN", 32'(busyN), 32'(1'b0));
      checkOutput("glitchValidN", 32'(validN), 32'(1'b0));
      checkFlags(1'b0);

      // Even parity: wrong then right parity bit for 0x43.
      applyStimulus(1'b1, 8'h43, 1'b0, 1'b1, 1'b1);
      waitTicks(12);
      checkFlags(1'b1);
      checkOutput("badParityValidE", 32'(validE), 32'(1'b0));
      applyStimulus(1'b1, 8'h43, 1'b1, 1'b1, 1'b1);
      waitTicks(12);
      checkOutput("goodParityHeadE", 32'(dataE), 32'(8'h43));
      drainCheck(1'b1);
      clearErr(1'b1);
      checkFlags(1'b1);

      // Framing error, clear, then a good frame.
      applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      waitTicks(12);
      checkFlags(1'b0);
      checkOutput("frameErrValidN", 32'(validN), 32'(1'b0));
      clearErr(1'b0);
      checkFlags(1'b0);
      applyStimulus(1'b0, 8'h3C, 1'b0, 1'b1, 1'b1);
      waitTicks(4);
      checkFlags(1'b0);
      drainCheck(1'b0);

      // Overrun: five back-to-back frames into a four-entry FIFO.
      for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 8'(i), 1'b0, 1'b1, 1'b1);
      waitTicks(4);
      checkFlags(1'b0);
      drainCheck(1'b0);
      clearErr(1'b0);

      // Reset in the middle of a frame, then a clean 0xA5.
      a5 = 8'hA5;
      driveBit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) driveBit(1'b0, a5[i]);
      checkOutput("midFrameBusyN", 32'(busyN), 32'(1'b1));
      rxN = 1'b1;
      rst = 1'b1;
      waitTicks(2);
      rst = 1'b0;
      tick();
      checkOutput("postResetBusyN", 32'(busyN), 32'(1'b0));
      checkOutput("postResetValidN", 32'(validN), 32'(1'b0));
      expN.delete(); gotN.delete(); expE.delete(); gotE.delete();
      occN = 0; occE = 0;
      mFerrN = 0; mPerrN = 0; mOvrN = 0;
      mFerrE = 0; mPerrE = 0; mOvrE = 0;
      applyStimulus(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
      waitTicks(4);
      checkFlags(1'b0);
      drainCheck(1'b0);

      // Randomized 8E2 traffic with occasional parity/stop faults, drains and clears.
      for (int k = 0; k < 14; k++) begin
         d    = 8'($urandom_range(0, 255));
         badP = ($urandom_range(0, 3) == 0);
         s0   = ($urandom_range(0, 5) != 0);
         s1   = ($urandom_range(0, 5) != 0);
         p    = (^d) ^ badP;
         applyStimulus(1'b1, d, p, s0, s1);
         waitTicks(12);
         checkFlags(1'b1);
         checkOutput("randValidE", 32'(validE), 32'(occE > 0));
         if ($urandom_range(0, 2) == 0) drainCheck(1'b1);
         if ($urandom_range(0, 4) == 0) clearErr(1'b1);
      end
      drainCheck(1'b1);
      checkFlags(1'b1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
